// File: rtl/lab3_cla_seq_adder.sv
// Sequential adder: one 4-bit CLA slice reused per nibble, LSB first.
// Ports: clk, rst (sync, active-high), [sub with LAB3_SEQ_SUB_EN], start, a, b, cin -> busy, done, sum, cout, ovf.
module lab3_cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef LAB3_SEQ_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;
  logic [3:0]       w_p;
  logic [3:0]       w_g;
  logic [4:1]       w_c;
  logic [3:0]       w_s;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_last;
  logic             w_accept;

`ifdef LAB3_SEQ_SUB_EN
  // a - b = a + ~b + 1
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub | cin;
`else
  assign w_b_in = b;
  assign w_c_in = cin;
`endif

  // Operands shift right each RUN cycle, so the live nibble is always [3:0]
  assign w_p = r_a[3:0] ^ r_b[3:0];
  assign w_g = r_a[3:0] & r_b[3:0];

  assign w_c[1] = w_g[0]
                | (w_p[0] & r_c);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & r_c);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & r_c);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_c);

  assign w_s = w_p ^ {w_c[3:1], r_c};

  // Result fills from the top; after NIB shifts nibble 0 sits at [3:0]
  generate
    if (WIDTH == 4) begin : g_one
      assign w_res_nxt = w_s;
    end else begin : g_multi
      assign w_res_nxt = {w_s, r_res[WIDTH-1:4]};
    end
  endgenerate

  assign w_last   = (r_cnt == LAST);
  assign w_accept = start && (r_state != S_RUN);

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= w_b_in;
      r_c   <= w_c_in;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 4;
      r_b   <= r_b >> 4;
      r_c   <= w_c[4];
      r_cnt <= r_cnt + 1'b1;
      r_res <= w_res_nxt;
      if (w_last) begin
        sum  <= w_res_nxt;
        cout <= w_c[4];
        ovf  <= w_c[3] ^ w_c[4];
      end
    end
  end

endmodule
